// File: rtl/bnn_accum_threshold.sv
// bnn_accum_threshold: saturating per-neuron accumulator with threshold activation and one-entry output register
module bnn_accum_threshold #(
  parameter int WIDTH_IN  = 10,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_sum,
  input  logic                 in_last,
  input  logic [ACC_WIDTH-1:0] threshold,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_act,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] out_count
);
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam logic [ACC_WIDTH-1:0] MAXV = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MINV = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [ACC_WIDTH-1:0] acc, thr_q, base_acc, base_thr, total;
  logic [ACC_WIDTH:0] sum;
  logic [CNT_WIDTH-1:0] cnt, base_cnt, cnt_n;
  logic sat, base_sat, sat_n, ovf, fire;
  assign in_ready = !out_valid || out_ready;
  assign fire = in_valid && in_ready;
  always_comb begin
    base_acc = state == ACCUM ? acc : '0;
    base_thr = state == ACCUM ? thr_q : threshold;
    base_cnt = state == ACCUM ? cnt : '0;
    base_sat = state == ACCUM ? sat : 1'b0;
    sum = {base_acc[ACC_WIDTH-1], base_acc} + {{(ACC_WIDTH+1-WIDTH_IN){in_sum[WIDTH_IN-1]}}, in_sum};
    ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
    total = !ovf ? sum[ACC_WIDTH-1:0] : sum[ACC_WIDTH] ? MINV : MAXV;
    cnt_n = &base_cnt ? base_cnt : base_cnt + 1'b1;
    sat_n = base_sat | ovf;
    state_n = !fire ? state : in_last ? IDLE : ACCUM;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst || (fire && in_last)) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
      thr_q <= rst ? '0 : thr_q;
    end else if (fire) begin
      acc <= total;
      cnt <= cnt_n;
      sat <= sat_n;
      thr_q <= base_thr;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_act <= 1'b0;
      out_acc <= '0;
      out_sat <= 1'b0;
      out_count <= '0;
    end else if (fire && in_last) begin
      out_valid <= 1'b1;
      out_act <= $signed(total) >= $signed(base_thr);
      out_acc <= total;
      out_sat <= sat_n;
      out_count <= cnt_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bnn_accum_threshold.sv
// tb_bnn_accum_threshold: directed table-driven bench for bnn_accum_threshold
module tb_bnn_accum_threshold;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_act, out_sat;
  logic [9:0] in_sum;
  logic [15:0] threshold, out_acc;
  logic [7:0] out_count;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int n;
    int beats [4];
    int thr;
    int acc;
    int act;
    int cnt;
    int sat;
  } vec_t;
  vec_t tab [7];
  bnn_accum_threshold dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_last(in_last), .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_acc(out_acc), .out_sat(out_sat), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic beat(input int s, input bit last, input int thr);
    in_valid = 1'b1;
    in_sum = s[9:0];
    in_last = last;
    threshold = thr[15:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic check_res(input string name, input int acc, input int act, input int cnt, input int sat);
    check({name, ".valid"}, int'(out_valid), 1);
    check({name, ".acc"}, int'($signed(out_acc)), acc);
    check({name, ".act"}, int'(out_act), act);
    check({name, ".count"}, int'(out_count), cnt);
    check({name, ".sat"}, int'(out_sat), sat);
  endtask
  initial begin
    tab[0] = '{4, '{3, -1, 5, 2}, 8, 9, 1, 4, 0};
    tab[1] = '{4, '{3, -1, 5, 2}, 9, 9, 1, 4, 0};
    tab[2] = '{1, '{-4, 0, 0, 0}, -4, -4, 1, 1, 0};
    tab[3] = '{2, '{1, 1, 0, 0}, 3, 2, 0, 2, 0};
    tab[4] = '{2, '{-100, 50, 0, 0}, -50, -50, 1, 2, 0};
    tab[5] = '{1, '{0, 0, 0, 0}, 1, 0, 0, 1, 0};
    tab[6] = '{3, '{511, -512, 511, 0}, 510, 510, 1, 3, 0};
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_sum = '0;
    threshold = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst.valid", int'(out_valid), 0);
    check("rst.acc", int'(out_acc), 0);
    check("rst.act", int'(out_act), 0);
    check("rst.count", int'(out_count), 0);
    check("rst.ready", int'(in_ready), 1);
    for (int v = 0; v < 7; v++) begin
      for (int b = 0; b < tab[v].n; b++) beat(tab[v].beats[b], b == tab[v].n - 1, tab[v].thr);
      check_res($sformatf("vec%0d", v), tab[v].acc, tab[v].act, tab[v].cnt, tab[v].sat);
    end
    beat(3, 0, 10);
    beat(-1, 0, 0);
    beat(5, 0, 0);
    beat(2, 1, 0);
    check_res("thr_sampled", 9, 0, 4, 0);
    for (int i = 0; i < 70; i++) beat(511, i == 69, 0);
    check_res("sat_pos", 32767, 1, 70, 1);
    for (int i = 0; i < 70; i++) beat(-512, i == 69, 0);
    check_res("sat_neg", -32768, 0, 70, 1);
    @(posedge clk);
    #1;
    check("drain.valid", int'(out_valid), 0);
    out_ready = 1'b0;
    beat(5, 1, 0);
    check_res("stall_load", 5, 1, 1, 0);
    in_valid = 1'b1;
    in_sum = 10'd100;
    in_last = 1'b1;
    threshold = 16'd200;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d.ready", i), int'(in_ready), 0);
      @(posedge clk);
      #1;
      check_res($sformatf("stall%0d", i), 5, 1, 1, 0);
    end
    out_ready = 1'b1;
    beat(-3, 1, 0);
    check_res("replace", -3, 0, 1, 0);
    @(posedge clk);
    #1;
    check("replace_drain.valid", int'(out_valid), 0);
    beat(20, 0, 5);
    beat(30, 0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.valid", int'(out_valid), 0);
    check("midrst.ready", int'(in_ready), 1);
    beat(7, 1, 0);
    check_res("post_rst", 7, 1, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
